// File: rtl/mid_square_rng_stream.sv
// Parametrised mid-square random number generator with an optional Weyl sequence.
// Output is a valid/ready stream; degenerate states are auto-reseeded in plain mode.
module mid_square_rng_stream #(
  parameter int unsigned          WIDTH        = 16,
  parameter logic [WIDTH-1:0]     DEFAULT_SEED = 16'h5678,
  parameter int unsigned          MODE         = 0,
  parameter logic [2*WIDTH-1:0]   WEYL_STEP    = 32'hB5AD4ECB
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] rand_out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       reseed_cnt_o
);

  localparam int unsigned MidLo = WIDTH / 2;

  typedef enum logic [0:0] {StIdle, StValid} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cur_q, cur_d;
  logic [2*WIDTH-1:0]   weyl_q, weyl_d;
  logic [7:0]           reseed_q, reseed_d;

  logic [2*WIDTH-1:0]   cur_ext;
  logic [2*WIDTH-1:0]   weyl_nxt;
  logic [2*WIDTH-1:0]   sq;
  logic [WIDTH-1:0]     mid;
  logic                 degen;
  logic                 handshake;

  // Next-value datapath.
  always_comb begin
    cur_ext  = {{WIDTH{1'b0}}, cur_q};
    weyl_nxt = weyl_q + WEYL_STEP;
    sq       = cur_ext * cur_ext;
    if (MODE != 0) begin
      sq = sq + weyl_nxt;
    end
    mid   = sq[MidLo +: WIDTH];
    degen = (MODE == 0) && ((mid == '0) || (mid == cur_q));
  end

  assign handshake = (state_q == StValid) && out_ready_i;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    weyl_d   = weyl_q;
    reseed_d = reseed_q;
    if (seed_load_i) begin
      // Load wins over advance; a coincident handshake still took the old value.
      cur_d   = (seed_in_i == '0) ? DEFAULT_SEED : seed_in_i;
      weyl_d  = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_d = StValid;
          end
        end
        StValid: begin
          if (handshake) begin
            if (degen) begin
              cur_d = DEFAULT_SEED;
              if (reseed_q != 8'hFF) begin
                reseed_d = reseed_q + 8'd1;
              end
            end else begin
              cur_d = mid;
            end
            if (MODE != 0) begin
              weyl_d = weyl_nxt;
            end
            state_d = enable_i ? StValid : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cur_q    <= DEFAULT_SEED;
      weyl_q   <= '0;
      reseed_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      weyl_q   <= weyl_d;
      reseed_q <= reseed_d;
    end
  end

  assign rand_out_o   = cur_q;
  assign out_valid_o  = (state_q == StValid);
  assign reseed_cnt_o = reseed_q;

endmodule

// File: tb/tb_mid_square_rng_stream.sv
// Scoreboard bench: stimulus queues expected values, per-DUT monitors pop on each handshake.
module tb_mid_square_rng_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // DUT A: W=16 plain, DUT B: W=16 Weyl, DUT C: W=8 plain.
  logic        a_en, a_ld, a_vld, a_rdy;
  logic [15:0] a_seed, a_out;
  logic [7:0]  a_cnt;
  logic        b_en, b_ld, b_vld, b_rdy;
  logic [15:0] b_seed, b_out;
  logic [7:0]  b_cnt;
  logic        c_en, c_ld, c_vld, c_rdy;
  logic [7:0]  c_seed, c_out;
  logic [7:0]  c_cnt;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  qc[$];

  mid_square_rng_stream #(.WIDTH(16), .DEFAULT_SEED(16'h5678), .MODE(0),
                          .WEYL_STEP(32'hB5AD4ECB)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(a_en), .seed_load_i(a_ld), .seed_in_i(a_seed),
    .rand_out_o(a_out), .out_valid_o(a_vld), .out_ready_i(a_rdy), .reseed_cnt_o(a_cnt));

  mid_square_rng_stream #(.WIDTH(16), .DEFAULT_SEED(16'h5678), .MODE(1),
                          .WEYL_STEP(32'hB5AD4ECB)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(b_en), .seed_load_i(b_ld), .seed_in_i(b_seed),
    .rand_out_o(b_out), .out_valid_o(b_vld), .out_ready_i(b_rdy), .reseed_cnt_o(b_cnt));

  mid_square_rng_stream #(.WIDTH(8), .DEFAULT_SEED(8'hA5), .MODE(0),
                          .WEYL_STEP(16'h4ECB)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(c_en), .seed_load_i(c_ld), .seed_in_i(c_seed),
    .rand_out_o(c_out), .out_valid_o(c_vld), .out_ready_i(c_rdy), .reseed_cnt_o(c_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: sample at the falling edge; valid && ready here means a transfer at the next rise.
  always @(negedge clk) begin
    if (rst_n && a_vld && a_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_xfer", {16'd0, a_out}, 32'hFFFF_FFFF);
      else chk("a_xfer", {16'd0, a_out}, {16'd0, qa.pop_front()});
    end
    if (rst_n && b_vld && b_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_xfer", {16'd0, b_out}, 32'hFFFF_FFFF);
      else chk("b_xfer", {16'd0, b_out}, {16'd0, qb.pop_front()});
    end
    if (rst_n && c_vld && c_rdy) begin
      if (qc.size() == 0) chk("c_unexpected_xfer", {24'd0, c_out}, 32'hFFFF_FFFF);
      else chk("c_xfer", {24'd0, c_out}, {24'd0, qc.pop_front()});
    end
  end

  task automatic drain_a(input int lim);
    for (int i = 0; i < lim && qa.size() != 0; i++) step();
    if (qa.size() != 0) chk("a_drain_timeout", qa.size(), 0);
    a_rdy = 1'b0;
  endtask

  task automatic drain_b(input int lim);
    for (int i = 0; i < lim && qb.size() != 0; i++) step();
    if (qb.size() != 0) chk("b_drain_timeout", qb.size(), 0);
    b_rdy = 1'b0;
  endtask

  task automatic drain_c(input int lim);
    for (int i = 0; i < lim && qc.size() != 0; i++) step();
    if (qc.size() != 0) chk("c_drain_timeout", qc.size(), 0);
    c_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_en, a_ld, a_rdy, b_en, b_ld, b_rdy, c_en, c_ld, c_rdy} = '0;
    a_seed = '0; b_seed = '0; c_seed = '0;
    step(); step();
    chk("rst_a_valid", a_vld, 0);
    chk("rst_a_out", a_out, 16'h5678);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_c_out", c_out, 8'hA5);

    // Stream after reset release.
    qa.push_back(16'h5678); qa.push_back(16'h34D8); qa.push_back(16'hE876);
    rst_n = 1'b1; a_en = 1'b1; a_rdy = 1'b1;
    chk("a_valid_before_first_edge", a_vld, 0);
    step();
    chk("a_valid_after_one_cycle", a_vld, 1);
    drain_a(20);
    chk("a_cnt_plain_stream", a_cnt, 0);

    // Seed 1 squares to mid 0 -> auto-reseed.
    a_ld = 1'b1; a_seed = 16'h0001;
    step();
    a_ld = 1'b0;
    chk("a_load_valid_low", a_vld, 0);
    chk("a_load_value", a_out, 16'h0001);
    qa.push_back(16'h0001); qa.push_back(16'h5678);
    a_rdy = 1'b1;
    drain_a(20);
    chk("a_cnt_after_reseed", a_cnt, 1);

    // Zero seed maps to the default seed.
    a_ld = 1'b1; a_seed = 16'h0000;
    step();
    a_ld = 1'b0;
    chk("a_zero_seed_value", a_out, 16'h5678);
    chk("a_zero_seed_cnt", a_cnt, 1);

    // Backpressure.
    qa.push_back(16'h5678);
    step();
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
    qa.push_back(16'h34D8); qa.push_back(16'hE876);
    for (int i = 0; i < 5; i++) begin
      chk("a_stall_valid", a_vld, 1);
      chk("a_stall_value", a_out, 16'h34D8);
      step();
    end
    a_en = 1'b0;
    step(); step();
    chk("a_stall_noen_valid", a_vld, 1);
    chk("a_stall_noen_value", a_out, 16'h34D8);
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
    chk("a_idle_after_noen", a_vld, 0);
    chk("a_successor_held", a_out, 16'hE876);
    a_en = 1'b1;
    step();
    a_rdy = 1'b1;
    drain_a(20);

    // Load coinciding with a handshake.
    a_ld = 1'b1; a_seed = 16'h1234; a_en = 1'b0;
    step();
    a_ld = 1'b0; a_en = 1'b1;
    step();
    qa.push_back(16'h1234);
    a_ld = 1'b1; a_seed = 16'h0001; a_rdy = 1'b1;
    step();
    a_ld = 1'b0; a_rdy = 1'b0;
    chk("a_load_hs_valid_low", a_vld, 0);
    chk("a_load_hs_value", a_out, 16'h0001);
    chk("a_load_hs_old_taken", qa.size(), 0);
    chk("a_load_hs_cnt", a_cnt, 1);
    step();
    chk("a_load_hs_new_valid", a_vld, 1);
    qa.push_back(16'h0001);
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
    chk("a_second_reseed_value", a_out, 16'h5678);
    chk("a_second_reseed_cnt", a_cnt, 2);

    // Weyl mode.
    qb.push_back(16'h5678); qb.push_back(16'hE227);
    b_en = 1'b1;
    step();
    b_rdy = 1'b1;
    drain_b(20);
    chk("b_cnt_zero", b_cnt, 0);

    // W=8: 0xA5^2 = 0x6A59, mid = 0xA5 = cur -> fixed point, reseed on every transfer.
    c_en = 1'b1;
    step();
    for (int i = 0; i < 2; i++) qc.push_back(8'hA5);
    c_rdy = 1'b1;
    drain_c(40);
    chk("c_cnt_2", c_cnt, 2);
    chk("c_value_2", c_out, 8'hA5);
    for (int i = 0; i < 253; i++) qc.push_back(8'hA5);
    c_rdy = 1'b1;
    drain_c(300);
    chk("c_cnt_255", c_cnt, 255);
    for (int i = 0; i < 9745; i++) qc.push_back(8'hA5);
    c_rdy = 1'b1;
    drain_c(9800);
    chk("c_cnt_saturated", c_cnt, 255);

    // Reset mid-stream.
    a_en = 1'b1;
    step();
    chk("a_prereset_valid", a_vld, 1);
    rst_n = 1'b0;
    step();
    chk("a_reset_valid", a_vld, 0);
    chk("a_reset_value", a_out, 16'h5678);
    chk("a_reset_cnt", a_cnt, 0);
    chk("c_reset_cnt", c_cnt, 0);
    chk("b_reset_valid", b_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
